// File: rtl/spi_dac_12bit.sv
// spi_dac_12bit: captures sample_in every SAMPLE_DIV clocks and writes it as one 16-bit frame to an MCP4921-class DAC.
// Latency: frame starts on the capture edge; last SCK fall at +32*CLK_DIV; CS released at +33*CLK_DIV.
// Backpressure: none upstream; a sample tick that lands mid-frame is dropped and flagged on overrun.
// Build option: define SPI_DAC_LDAC_EN to add a one-half-period active-low LDAC strobe after CS rises;
// without it dac_ldac_n is tied low and the DAC updates on the CS rising edge.
module spi_dac_12bit #(
  parameter int         CLK_DIV    = 3,
  parameter int         SAMPLE_DIV = 272,
  parameter logic [3:0] CFG_BITS   = 4'b0011
) (
  input  logic        clk12MHz,
  input  logic        rst,
  input  logic [11:0] sample_in,
  output logic        dac_sck,
  output logic        dac_cs_n,
  output logic        dac_mosi,
  output logic        dac_ldac_n,
  output logic        busy,
  output logic        sample_tick,
  output logic        overrun
);

  localparam int SW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [SW-1:0] SAMP_LAST = SW'(SAMPLE_DIV - 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);

`ifdef SPI_DAC_LDAC_EN
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, LDAC} state_t;
`else
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;
`endif

  state_t        state;
  logic [SW-1:0] samp_cnt;
  logic [DW-1:0] div_cnt;
  logic [15:0]   shreg;
  logic [3:0]    bit_cnt;
  logic          samp_wrap;
  logic          div_step;

  assign samp_wrap = (samp_cnt == SAMP_LAST);
  assign div_step  = (div_cnt == DIV_LAST);

  // Free-running sample-rate counter, independent of the frame state.
  always_ff @(posedge clk12MHz) begin
    if (rst) begin
      samp_cnt <= '0;
    end else if (samp_wrap) begin
      samp_cnt <= '0;
    end else begin
      samp_cnt <= samp_cnt + 1'b1;
    end
  end

`ifndef SPI_DAC_LDAC_EN
  // Without the strobe the DAC latches on CS rising, so LDAC is held asserted.
  assign dac_ldac_n = 1'b0;
`endif

  // Frame sequencer: capture on wrap, then step SETUP/SHIFT/HOLD(/LDAC) every CLK_DIV clocks.
  always_ff @(posedge clk12MHz) begin
    if (rst) begin
      state       <= IDLE;
      div_cnt     <= '0;
      shreg       <= '0;
      bit_cnt     <= '0;
      dac_sck     <= 1'b0;
      dac_cs_n    <= 1'b1;
      dac_mosi    <= 1'b0;
      busy        <= 1'b0;
      sample_tick <= 1'b0;
      overrun     <= 1'b0;
`ifdef SPI_DAC_LDAC_EN
      dac_ldac_n  <= 1'b1;
`endif
    end else begin
      sample_tick <= 1'b0;
      overrun     <= 1'b0;
      div_cnt     <= div_step ? '0 : div_cnt + 1'b1;
      if (samp_wrap && state == IDLE) begin
        // Config nibble and data are frozen here; later sample_in changes cannot reach this frame.
        shreg       <= {CFG_BITS, sample_in};
        bit_cnt     <= '0;
        dac_cs_n    <= 1'b0;
        dac_mosi    <= CFG_BITS[3];
        busy        <= 1'b1;
        sample_tick <= 1'b1;
        div_cnt     <= '0;
        state       <= SETUP;
      end else begin
        // A wrap mid-frame drops that sample but leaves the frame in flight alone.
        if (samp_wrap) overrun <= 1'b1;
        if (div_step) begin
          case (state)
            SETUP: begin
              dac_sck <= 1'b1;
              state   <= SHIFT;
            end
            SHIFT: begin
              if (!dac_sck) begin
                dac_sck <= 1'b1;
              end else begin
                // Data changes only on the falling toggle so it is stable at the next rising edge.
                dac_sck <= 1'b0;
                if (bit_cnt == 4'd15) begin
                  dac_mosi <= 1'b0;
                  state    <= HOLD;
                end else begin
                  shreg    <= {shreg[14:0], 1'b0};
                  dac_mosi <= shreg[14];
                  bit_cnt  <= bit_cnt + 1'b1;
                end
              end
            end
            HOLD: begin
              dac_cs_n <= 1'b1;
`ifdef SPI_DAC_LDAC_EN
              dac_ldac_n <= 1'b0;
              state      <= LDAC;
`else
              busy  <= 1'b0;
              state <= IDLE;
`endif
            end
`ifdef SPI_DAC_LDAC_EN
            LDAC: begin
              dac_ldac_n <= 1'b1;
              busy       <= 1'b0;
              state      <= IDLE;
            end
`endif
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_dac_12bit.sv
// tb_spi_dac_12bit: directed checks of frame content, timing, reset and overrun for spi_dac_12bit.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_spi_dac_12bit;

  localparam int CLK_DIV = 3;
`ifdef SPI_DAC_LDAC_EN
  localparam int EXP_BUSY_FALL  = 102;
  localparam int EXP_LDAC_LO    = 3;
  localparam int EXP_LDAC_FIRST = 99;
  localparam logic EXP_LDAC_RST = 1'b1;
`else
  localparam int EXP_BUSY_FALL  = 99;
  localparam int EXP_LDAC_LO    = 120;
  localparam int EXP_LDAC_FIRST = 1;
  localparam logic EXP_LDAC_RST = 1'b0;
`endif

  logic        clk12MHz;
  logic        rst;
  logic [11:0] sample_in;
  logic        dac_sck, dac_cs_n, dac_mosi, dac_ldac_n, busy, sample_tick, overrun;

  logic        rst2;
  logic [11:0] sample_in2;
  logic        sck2, cs2_n, mosi2, ldac2_n, busy2, tick2, ov2;

  int n_chk  = 0;
  int n_pass = 0;

  spi_dac_12bit u_dut (
    .clk12MHz(clk12MHz), .rst(rst), .sample_in(sample_in),
    .dac_sck(dac_sck), .dac_cs_n(dac_cs_n), .dac_mosi(dac_mosi), .dac_ldac_n(dac_ldac_n),
    .busy(busy), .sample_tick(sample_tick), .overrun(overrun)
  );

  // Short sample period so ticks land mid-frame.
  spi_dac_12bit #(.CLK_DIV(3), .SAMPLE_DIV(60), .CFG_BITS(4'b0011)) u_dut_ov (
    .clk12MHz(clk12MHz), .rst(rst2), .sample_in(sample_in2),
    .dac_sck(sck2), .dac_cs_n(cs2_n), .dac_mosi(mosi2), .dac_ldac_n(ldac2_n),
    .busy(busy2), .sample_tick(tick2), .overrun(ov2)
  );

  initial clk12MHz = 1'b0;
  always #5 clk12MHz = ~clk12MHz;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk12MHz);
    #1;
  endtask

  // Advance until sample_tick is seen; n is the number of edges taken (bounded).
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!sample_tick && n < 400);
  endtask

  // Observe 120 edges after the capture edge T; optionally change sample_in before edge T+chg_at.
  task automatic run_frame(input logic [11:0] chg_val, input int chg_at,
                           output logic [15:0] bits, output int nrise, output int badhi,
                           output int cs_rise, output int busy_fall, output int ldac_lo,
                           output int ldac_first, output int ticks, output logic mosi_end);
    logic prev_sck;
    int   hi;
    bits = '0; nrise = 0; badhi = 0; cs_rise = -1; busy_fall = -1;
    ldac_lo = 0; ldac_first = -1; ticks = 0; hi = 0;
    prev_sck = dac_sck;
    for (int t = 1; t <= 120; t++) begin
      if (t == chg_at) sample_in = chg_val;
      tick();
      if (dac_sck && !prev_sck) begin
        bits = {bits[14:0], dac_mosi};
        nrise++;
        hi = 0;
      end
      if (dac_sck) hi++;
      if (!dac_sck && prev_sck && hi != CLK_DIV) badhi++;
      if (dac_cs_n && cs_rise < 0) cs_rise = t;
      if (!busy && busy_fall < 0) busy_fall = t;
      if (!dac_ldac_n) begin
        ldac_lo++;
        if (ldac_first < 0) ldac_first = t;
      end
      if (sample_tick) ticks++;
      prev_sck = dac_sck;
    end
    mosi_end = dac_mosi;
  endtask

  // Overrun-instance monitor: counts ticks, overruns and SCK pulses per frame.
  int   ov2_cnt = 0, ov2_bad = 0, tick2_cnt = 0, frames2 = 0, bad2 = 0, pulse2 = 0;
  int   ov1_cnt = 0;
  logic prev_sck2 = 1'b0, prev_cs2 = 1'b1;
  always begin
    @(posedge clk12MHz);
    #1;
    if (rst2 === 1'b0) begin
      if (ov2) begin
        ov2_cnt++;
        if (!busy2) ov2_bad++;
      end
      if (tick2) tick2_cnt++;
      if (sck2 && !prev_sck2) pulse2++;
      if (!cs2_n && prev_cs2) pulse2 = 0;
      if (cs2_n && !prev_cs2) begin
        frames2++;
        if (pulse2 != 16) bad2++;
      end
    end
    if (rst === 1'b0 && overrun) ov1_cnt++;
    prev_sck2 = sck2;
    prev_cs2  = cs2_n;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] bits;
    int nrise, badhi, cs_rise, busy_fall, ldac_lo, ldac_first, ticks, n, tmp;
    logic mosi_end;

    rst = 1'b1; rst2 = 1'b1;
    sample_in = 12'hABC; sample_in2 = 12'h555;
    tick(); tick(); tick();
    check("rst_sck",    dac_sck,     1'b0);
    check("rst_cs_n",   dac_cs_n,    1'b1);
    check("rst_mosi",   dac_mosi,    1'b0);
    check("rst_ldac_n", dac_ldac_n,  EXP_LDAC_RST);
    check("rst_busy",   busy,        1'b0);
    check("rst_tick",   sample_tick, 1'b0);
    check("rst_ovr",    overrun,     1'b0);
    rst = 1'b0; rst2 = 1'b0;

    // Frame 1: 0x3ABC, first capture on the 272nd edge after release.
    wait_tick(n);
    check("first_tick_edge", n, 272);
    check("t_cs_n",  dac_cs_n, 1'b0);
    check("t_busy",  busy,     1'b1);
    check("t_mosi",  dac_mosi, 1'b0);
    run_frame(12'h000, 0, bits, nrise, badhi, cs_rise, busy_fall, ldac_lo, ldac_first, ticks, mosi_end);
    check("f1_bits",      bits,       16'h3ABC);
    check("f1_nrise",     nrise,      16);
    check("f1_badhi",     badhi,      0);
    check("f1_cs_rise",   cs_rise,    99);
    check("f1_busy_fall", busy_fall,  EXP_BUSY_FALL);
    check("f1_ldac_lo",   ldac_lo,    EXP_LDAC_LO);
    check("f1_ldac_1st",  ldac_first, EXP_LDAC_FIRST);
    check("f1_ticks",     ticks,      0);
    check("f1_mosi_end",  mosi_end,   1'b0);

    // Frame 2 carries 0x000 even though sample_in goes to 0xFFF at T+40.
    sample_in = 12'h000;
    wait_tick(n);
    check("f2_interval", n, 152);
    run_frame(12'hFFF, 40, bits, nrise, badhi, cs_rise, busy_fall, ldac_lo, ldac_first, ticks, mosi_end);
    check("f2_bits",  bits,  16'h3000);
    check("f2_nrise", nrise, 16);

    // Frame 3 picks up 0xFFF.
    wait_tick(n);
    check("f3_interval", n, 152);
    run_frame(12'hFFF, 0, bits, nrise, badhi, cs_rise, busy_fall, ldac_lo, ldac_first, ticks, mosi_end);
    check("f3_bits",    bits,    16'h3FFF);
    check("f3_cs_rise", cs_rise, 99);

    // Reset for one cycle at T+50, mid-shift.
    wait_tick(n);
    check("f4_interval", n, 152);
    for (int i = 1; i <= 49; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_cs_n",   dac_cs_n,   1'b1);
    check("mid_rst_sck",    dac_sck,    1'b0);
    check("mid_rst_mosi",   dac_mosi,   1'b0);
    check("mid_rst_ldac_n", dac_ldac_n, EXP_LDAC_RST);
    check("mid_rst_busy",   busy,       1'b0);
    wait_tick(n);
    check("post_rst_edge", n, 272);
    run_frame(12'h123, 0, bits, nrise, badhi, cs_rise, busy_fall, ldac_lo, ldac_first, ticks, mosi_end);
    check("f5_bits",      bits,      16'h3FFF);
    check("f5_busy_fall", busy_fall, EXP_BUSY_FALL);

    // Overrun instance: ticks and overruns alternate, frames stay whole.
    check("ov_seen",       (ov2_cnt > 0) ? 1 : 0, 1);
    tmp = tick2_cnt - ov2_cnt;
    check("ov_alternate",  (tmp == 0 || tmp == 1) ? 1 : 0, 1);
    check("ov_when_idle",  ov2_bad, 0);
    check("ov_frames",     (frames2 > 0) ? 1 : 0, 1);
    check("ov_bad_frames", bad2, 0);
    check("main_no_ovr",   ov1_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
